control_unit_seq: RTL and testbench

Registered decode/control stage for the pipelined ARM-like core with camera ops. It decodes funct/opcode in D and drives the D-only controls (RegSrcD, ImmSrcD) combinationally. It registers the E-stage control bundle with stall/flush handling, and sequences multi-cycle MULT and AVERAGE ops by raising busy until they complete.

---
 rtl/control_unit_seq_if.sv | 36 +++
 rtl/control_unit_seq.sv | 172 +++++++++++++++++
 tb/tb_control_unit_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/control_unit_seq_if.sv
// D-to-E control handshake bundle for control_unit_seq; master drives the D-stage side.
interface control_unit_seq_if #(
  parameter int ALU_CTRL_W = 4
);
  logic                  valid_d;
  logic [5:0]            funct;
  logic [1:0]            opcode;
  logic                  stall_in;
  logic                  flush_e;
  logic                  ready_d;
  logic [1:0]            RegSrcD;
  logic [1:0]            ImmSrcD;
  logic                  valid_e;
  logic                  ALUSrcE;
  logic [ALU_CTRL_W-1:0] ALUControlE;
  logic                  MemToRegE;
  logic                  RegWriteE;
  logic                  PlusOneE;
  logic                  BranchE;
  logic                  PCSrcE;
  logic [1:0]            FlagWE;
  logic                  illegal_e;
  logic                  busy;

  modport master (
    output valid_d, funct, opcode, stall_in, flush_e,
    input  ready_d, RegSrcD, ImmSrcD, valid_e, ALUSrcE, ALUControlE, MemToRegE,
           RegWriteE, PlusOneE, BranchE, PCSrcE, FlagWE, illegal_e, busy
  );

  modport slave (
    input  valid_d, funct, opcode, stall_in, flush_e,
    output ready_d, RegSrcD, ImmSrcD, valid_e, ALUSrcE, ALUControlE, MemToRegE,
           RegWriteE, PlusOneE, BranchE, PCSrcE, FlagWE, illegal_e, busy
  );
endinterface

// File: rtl/control_unit_seq.sv
// Decode/control stage: comb D controls, registered E bundle, busy sequencing for MULT/AVERAGE.
// Optional PERF_COUNT_EN adds issue / multi-cycle-stall / flush counters.
module control_unit_seq #(
  parameter int ALU_CTRL_W = 4,
  parameter int MULT_LAT   = 2,
  parameter int AV_LAT     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef PERF_COUNT_EN
  output logic [31:0]          perf_issued,
  output logic [31:0]          perf_mc_stall,
  output logic [31:0]          perf_flush,
`endif
  control_unit_seq_if.slave    bus
);
  localparam logic [3:0] F_NOP = 4'd0, F_ADD = 4'd1, F_SUB = 4'd2, F_MULT = 4'd3,
                         F_LOAD = 4'd4, F_STR = 4'd5, F_AVERAGE = 4'd6, F_STR_ONE = 4'd7,
                         F_PIC = 4'd8, F_B = 4'd9;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOP = ALU_CTRL_W'(0), ALU_ADD = ALU_CTRL_W'(1),
                                    ALU_SUB = ALU_CTRL_W'(2), ALU_MULT = ALU_CTRL_W'(3),
                                    ALU_BUF = ALU_CTRL_W'(4), ALU_AV = ALU_CTRL_W'(5);
  localparam logic [3:0] MULT_LAT4 = 4'(MULT_LAT);
  localparam logic [3:0] AV_LAT4   = 4'(AV_LAT);

  typedef struct packed {
    logic                  valid;
    logic                  alu_src;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic                  plus_one;
    logic                  branch;
    logic                  pc_src;
    logic [1:0]            flag_w;
    logic                  illegal;
  } ectl_t;

  typedef enum logic {S_IDLE, S_EXEC} state_e;

  logic [3:0] w_cmd;
  logic       w_s;
  logic       w_unused;
  logic       w_illegal;
  ectl_t      w_dec;
  ectl_t      r_e;
  logic       w_busy;
  logic       w_advance;
  logic [3:0] w_lat;
  logic       w_start;
  state_e     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;

  assign w_cmd     = bus.funct[4:1];
  assign w_s       = bus.funct[0];
  assign w_unused  = bus.funct[5];
  assign w_illegal = (w_cmd > F_B) || (bus.opcode == 2'b11);

  always_comb begin
    w_dec            = '0;
    w_dec.valid      = 1'b1;
    w_dec.alu_src    = bus.opcode[0];
    w_dec.plus_one   = (w_cmd == F_STR_ONE);
    if (w_illegal) begin
      w_dec.illegal = 1'b1;
    end else begin
      case (w_cmd)
        F_NOP:     w_dec.alu_ctrl = ALU_NOP;
        F_ADD:     w_dec.alu_ctrl = ALU_ADD;
        F_SUB:     w_dec.alu_ctrl = ALU_SUB;
        F_MULT:    w_dec.alu_ctrl = ALU_MULT;
        F_AVERAGE: w_dec.alu_ctrl = ALU_AV;
        default:   w_dec.alu_ctrl = ALU_BUF;
      endcase
      w_dec.mem_to_reg = (w_cmd == F_LOAD);
      w_dec.reg_write  = !((w_cmd == F_STR) || (w_cmd == F_PIC) || (w_cmd == F_NOP));
      w_dec.branch     = (bus.opcode == 2'b10);
      w_dec.pc_src     = (bus.opcode == 2'b10);
      // Flag enables follow the freshly decoded ALU code, not the E register.
      w_dec.flag_w     = {w_s, w_s & ((w_dec.alu_ctrl == ALU_ADD) || (w_dec.alu_ctrl == ALU_SUB))};
    end
  end

  assign bus.RegSrcD = {(bus.opcode == 2'b01) & ~w_s, bus.opcode == 2'b10};
  assign bus.ImmSrcD = {w_cmd == F_B, (w_cmd == F_STR) || (w_cmd == F_LOAD)};

  assign w_busy      = (r_state == S_EXEC);
  assign w_advance   = ~bus.stall_in & ~w_busy;
  assign bus.ready_d = w_advance & ~bus.flush_e & ~reset;

  always_ff @(posedge clk) begin
    if (reset || bus.flush_e) begin
      r_e <= '0;
    end else if (w_advance) begin
      r_e <= bus.valid_d ? w_dec : '0;
    end
  end

  always_comb begin
    w_lat = 4'd1;
    if (w_dec.alu_ctrl == ALU_MULT) w_lat = MULT_LAT4;
    else if (w_dec.alu_ctrl == ALU_AV) w_lat = AV_LAT4;
  end
  assign w_start = w_advance & bus.valid_d & ~bus.flush_e & (w_lat > 4'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_EXEC;
          w_cnt_nxt   = w_lat - 4'd1;
        end
      end
      S_EXEC: begin
        if (bus.flush_e || (r_cnt <= 4'd1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign bus.valid_e     = r_e.valid;
  assign bus.ALUSrcE     = r_e.alu_src;
  assign bus.ALUControlE = r_e.alu_ctrl;
  assign bus.MemToRegE   = r_e.mem_to_reg;
  assign bus.RegWriteE   = r_e.reg_write;
  assign bus.PlusOneE    = r_e.plus_one;
  assign bus.BranchE     = r_e.branch;
  assign bus.PCSrcE      = r_e.pc_src;
  assign bus.FlagWE      = r_e.flag_w;
  assign bus.illegal_e   = r_e.illegal;
  assign bus.busy        = w_busy;

`ifdef PERF_COUNT_EN
  logic [31:0] r_perf_issued, r_perf_mc_stall, r_perf_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_issued   <= 32'd0;
      r_perf_mc_stall <= 32'd0;
      r_perf_flush    <= 32'd0;
    end else begin
      if (w_advance && bus.valid_d && !bus.flush_e) r_perf_issued <= r_perf_issued + 32'd1;
      if (w_busy) r_perf_mc_stall <= r_perf_mc_stall + 32'd1;
      if (bus.flush_e && r_e.valid) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_issued   = r_perf_issued;
  assign perf_mc_stall = r_perf_mc_stall;
  assign perf_flush    = r_perf_flush;
`endif
endmodule

// File: tb/tb_control_unit_seq.sv
// Scoreboard bench for control_unit_seq: driver pushes model predictions, negedge monitor compares.
module tb_control_unit_seq;
  localparam int W  = 4;
  localparam int ML = 2;
  localparam int AL = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  control_unit_seq_if #(.ALU_CTRL_W(W)) bus ();
`ifdef PERF_COUNT_EN
  logic [31:0] perf_issued, perf_mc_stall, perf_flush;
`endif

  control_unit_seq #(.ALU_CTRL_W(W), .MULT_LAT(ML), .AV_LAT(AL)) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef PERF_COUNT_EN
    .perf_issued  (perf_issued),
    .perf_mc_stall(perf_mc_stall),
    .perf_flush   (perf_flush),
`endif
    .bus          (bus)
  );

  typedef struct packed {
    logic       valid, alusrc, memtoreg, regwrite, plusone, branch, pcsrc, illegal;
    logic [3:0] alu;
    logic [1:0] flagw;
  } e_t;

  typedef struct packed {
    e_t          e;
    logic        busy, ready;
    logic [1:0]  regsrc, immsrc;
    logic [31:0] pi, pm, pf;
  } snap_t;

  snap_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // ALU code per cmd value; entries 10..15 are illegal commands.
  int unsigned alu_tab [16] = '{0, 1, 2, 3, 4, 4, 5, 4, 4, 4, 0, 0, 0, 0, 0, 0};

  e_t          m_e;
  int          m_busy_left;
  logic [31:0] m_pi, m_pm, m_pf;
  logic        p_rst, p_valid, p_stall, p_flush;
  logic [3:0]  p_cmd;
  logic        p_s;
  logic [1:0]  p_op;

  function automatic e_t decode(input logic [3:0] cmd, input logic s, input logic [1:0] op);
    e_t d;
    d         = '0;
    d.valid   = 1'b1;
    d.alusrc  = op[0];
    d.plusone = (cmd == 4'd7);
    if (cmd > 4'd9 || op == 2'd3) begin
      d.illegal = 1'b1;
    end else begin
      d.alu      = 4'(alu_tab[cmd]);
      d.memtoreg = (cmd == 4'd4);
      d.regwrite = !(cmd == 4'd0 || cmd == 4'd5 || cmd == 4'd8);
      d.branch   = (op == 2'd2);
      d.pcsrc    = (op == 2'd2);
      d.flagw    = {s, s && (d.alu == 4'd1 || d.alu == 4'd2)};
    end
    return d;
  endfunction

  // Advance the model by one clock using the inputs present at that edge.
  task automatic model_clock();
    e_t d;
    int lat;
    if (p_rst) begin
      m_e = '0; m_busy_left = 0; m_pi = 0; m_pm = 0; m_pf = 0;
    end else begin
      if (m_busy_left > 0) m_pm = m_pm + 1;
      if (p_flush && m_e.valid) m_pf = m_pf + 1;
      if (p_flush) begin
        m_e = '0; m_busy_left = 0;
      end else if (!p_stall && m_busy_left == 0) begin
        if (p_valid) begin
          d    = decode(p_cmd, p_s, p_op);
          m_e  = d;
          m_pi = m_pi + 1;
          lat  = (d.alu == 4'd3) ? ML : (d.alu == 4'd5) ? AL : 1;
          m_busy_left = lat - 1;
        end else begin
          m_e = '0;
        end
      end else if (m_busy_left > 0) begin
        m_busy_left = m_busy_left - 1;
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] cmd, input logic s,
                      input logic [1:0] op, input logic st, input logic fl);
    snap_t sn;
    @(posedge clk);
    #1;
    model_clock();
    reset        = r;
    bus.valid_d  = v;
    bus.funct    = {1'($urandom_range(1)), cmd, s};
    bus.opcode   = op;
    bus.stall_in = st;
    bus.flush_e  = fl;
    p_rst = r; p_valid = v; p_cmd = cmd; p_s = s; p_op = op; p_stall = st; p_flush = fl;
    sn.e      = m_e;
    sn.busy   = (m_busy_left > 0);
    sn.ready  = !r && !st && !fl && (m_busy_left == 0);
    sn.regsrc = {op == 2'd1 && !s, op == 2'd2};
    sn.immsrc = {cmd == 4'd9, cmd == 4'd5 || cmd == 4'd4};
    sn.pi = m_pi; sn.pm = m_pm; sn.pf = m_pf;
    q.push_back(sn);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
  endtask

  initial begin : monitor
    snap_t s;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        s = q.pop_front();
        chk("valid_e",     32'(bus.valid_e),     32'(s.e.valid));
        chk("ALUControlE", 32'(bus.ALUControlE), 32'(s.e.alu));
        chk("ALUSrcE",     32'(bus.ALUSrcE),     32'(s.e.alusrc));
        chk("MemToRegE",   32'(bus.MemToRegE),   32'(s.e.memtoreg));
        chk("RegWriteE",   32'(bus.RegWriteE),   32'(s.e.regwrite));
        chk("PlusOneE",    32'(bus.PlusOneE),    32'(s.e.plusone));
        chk("BranchE",     32'(bus.BranchE),     32'(s.e.branch));
        chk("PCSrcE",      32'(bus.PCSrcE),      32'(s.e.pcsrc));
        chk("FlagWE",      32'(bus.FlagWE),      32'(s.e.flagw));
        chk("illegal_e",   32'(bus.illegal_e),   32'(s.e.illegal));
        chk("busy",        32'(bus.busy),        32'(s.busy));
        chk("ready_d",     32'(bus.ready_d),     32'(s.ready));
        chk("RegSrcD",     32'(bus.RegSrcD),     32'(s.regsrc));
        chk("ImmSrcD",     32'(bus.ImmSrcD),     32'(s.immsrc));
`ifdef PERF_COUNT_EN
        chk("perf_issued",   perf_issued,   s.pi);
        chk("perf_mc_stall", perf_mc_stall, s.pm);
        chk("perf_flush",    perf_flush,    s.pf);
`endif
      end
    end
  end

  initial begin : driver
    logic [3:0] cmd;
    logic [1:0] op;
    reset = 1'b1; bus.valid_d = 1'b0; bus.funct = '0; bus.opcode = '0;
    bus.stall_in = 1'b0; bus.flush_e = 1'b0;
    p_rst = 1'b1; p_valid = 1'b0; p_cmd = '0; p_s = 1'b0; p_op = '0; p_stall = 1'b0; p_flush = 1'b0;
    m_e = '0; m_busy_left = 0; m_pi = 0; m_pm = 0; m_pf = 0;

    step(1, 0, 4'd0, 0, 2'd0, 0, 0);
    step(1, 0, 4'd0, 0, 2'd0, 0, 0);
    step(0, 1, 4'd1, 1, 2'd0, 0, 0);   // FADD with S
    step(0, 1, 4'd3, 0, 2'd0, 0, 0);   // FMULT
    repeat (3) step(0, 1, 4'd1, 0, 2'd0, 0, 0);
    step(0, 1, 4'd6, 1, 2'd0, 0, 0);   // FAVERAGE
    step(0, 0, 4'd0, 0, 2'd0, 0, 0);
    step(0, 0, 4'd0, 0, 2'd0, 0, 1);   // flush on second busy cycle
    step(0, 1, 4'd15, 1, 2'd0, 0, 0);
    step(0, 1, 4'd5, 1, 2'd3, 0, 0);
    step(0, 1, 4'd5, 0, 2'd1, 0, 0);
    repeat (3) step(0, 1, 4'd4, 0, 2'd1, 1, 0);  // FLOAD under stall
    step(0, 1, 4'd4, 0, 2'd1, 0, 0);
    step(0, 1, 4'd9, 0, 2'd2, 0, 0);
    step(0, 0, 4'd0, 0, 2'd0, 0, 0);

    for (int i = 0; i < 500; i++) begin
      cmd = ($urandom_range(7) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(9));
      op  = 2'($urandom_range(3));
      step($urandom_range(63) == 0, $urandom_range(3) != 0, cmd, 1'($urandom_range(1)), op,
           $urandom_range(4) == 0, $urandom_range(7) == 0);
    end

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
